// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the multiply/divide unit: request codes and counter sizing.
package mul_div_unit_pkg;

  localparam int MD_OP_LEN = 3;
  localparam int COUNT_W   = 4;

  typedef enum logic [MD_OP_LEN-1:0] {
    MD_OP_NONE  = 3'd0,
    MD_OP_MULT  = 3'd1,
    MD_OP_MULTU = 3'd2,
    MD_OP_DIV   = 3'd3,
    MD_OP_DIVU  = 3'd4,
    MD_OP_MTHI  = 3'd5,
    MD_OP_MTLO  = 3'd6
  } md_op_e;

  // True for the long-latency requests that occupy the unit and stall decode.
  function automatic logic is_mul_div(input logic [MD_OP_LEN-1:0] op);
    return (op >= MD_OP_MULT) && (op <= MD_OP_DIVU);
  endfunction

endpackage

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit with HI/LO registers; results land a fixed
// number of cycles after issue, and busy stalls HI/LO-class instructions.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [MD_OP_LEN-1:0] op,
  input  logic [31:0]          a,
  input  logic [31:0]          b,
  output logic                 busy,
  output logic [31:0]          hi,
  output logic [31:0]          lo
);

  logic [COUNT_W-1:0]   count;
  logic [MD_OP_LEN-1:0] op_q;
  logic [31:0]          a_q;
  logic [31:0]          b_q;

  logic                 res_we;
  logic [31:0]          res_hi;
  logic [31:0]          res_lo;
  logic [63:0]          prod;

  // Stall is combinational so decode sees it in the issue cycle itself.
  assign busy = (count != '0) | is_mul_div(op);

  // Result of the latched operation; a zero divisor suppresses the write.
  always_comb begin
    res_we = 1'b0;
    res_hi = hi;
    res_lo = lo;
    prod   = 64'd0;
    case (op_q)
      MD_OP_MULT: begin
        prod   = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
        res_we = 1'b1;
        res_hi = prod[63:32];
        res_lo = prod[31:0];
      end
      MD_OP_MULTU: begin
        prod   = {32'd0, a_q} * {32'd0, b_q};
        res_we = 1'b1;
        res_hi = prod[63:32];
        res_lo = prod[31:0];
      end
      MD_OP_DIV: begin
        if (b_q != 32'd0) begin
          res_we = 1'b1;
          if (a_q == 32'h8000_0000 && b_q == 32'hFFFF_FFFF) begin
            res_lo = 32'h8000_0000;
            res_hi = 32'd0;
          end else begin
            res_lo = $signed(a_q) / $signed(b_q);
            res_hi = $signed(a_q) % $signed(b_q);
          end
        end
      end
      MD_OP_DIVU: begin
        if (b_q != 32'd0) begin
          res_we = 1'b1;
          res_lo = a_q / b_q;
          res_hi = a_q % b_q;
        end
      end
      default: ;
    endcase
  end

  // Countdown, operand capture and HI/LO update; requests are ignored while counting.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      hi    <= '0;
      lo    <= '0;
    end else if (count == '0) begin
      case (op)
        MD_OP_MULT, MD_OP_MULTU: begin
          op_q  <= op;
          a_q   <= a;
          b_q   <= b;
          count <= COUNT_W'(MUL_CYCLES);
        end
        MD_OP_DIV, MD_OP_DIVU: begin
          op_q  <= op;
          a_q   <= a;
          b_q   <= b;
          count <= COUNT_W'(DIV_CYCLES);
        end
        MD_OP_MTHI: hi <= a;
        MD_OP_MTLO: lo <= a;
        default: ;
      endcase
    end else if (count == COUNT_W'(1)) begin
      count <= '0;
      if (res_we) begin
        hi <= res_hi;
        lo <= res_lo;
      end
    end else begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: expected HI/LO and busy length are queued
// at issue; a monitor compares them when busy falls.
module tb_mul_div_unit;
  import mul_div_unit_pkg::*;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
    string       name;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [MD_OP_LEN-1:0] op;
  logic [31:0]          a;
  logic [31:0]          b;
  logic                 busy;
  logic [31:0]          hi;
  logic [31:0]          lo;

  exp_t sb[$];
  int   compared = 0;
  int   mismatched = 0;
  int   run = 0;
  bit   mon_en = 1'b0;

  mul_div_unit #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .op(op), .a(a), .b(b),
    .busy(busy), .hi(hi), .lo(lo)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports any difference.
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Drives one request for exactly one cycle, returning 1 time unit after the accepting edge.
  task automatic applyStimulus(input logic [MD_OP_LEN-1:0] o, input logic [31:0] av, input logic [31:0] bv);
    op = o;
    a  = av;
    b  = bv;
    @(posedge clk);
    #1;
    op = MD_OP_NONE;
    a  = 32'd0;
    b  = 32'd0;
  endtask

  task automatic expect_result(input string name, input logic [31:0] h, input logic [31:0] l, input int cyc);
    exp_t e;
    e.hi = h; e.lo = l; e.cycles = cyc; e.name = name;
    sb.push_back(e);
  endtask

  // Waits (bounded) until the monitor has consumed every queued expectation.
  task automatic waitDone(input string name);
    int i;
    for (i = 0; i < 40; i++) begin
      @(posedge clk);
      #2;
      if (sb.size() == 0 && !busy) break;
    end
    if (i == 40) checkOutput({name, "_timeout"}, 32'(sb.size()), 32'd0);
  endtask

  // Monitor: counts busy cycles and compares HI/LO on the first idle cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      if (busy === 1'b1) begin
        run++;
      end else if (run > 0) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_busy", 32'(run), 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          checkOutput({e.name, "_busy_cycles"}, 32'(run), 32'(e.cycles));
          checkOutput({e.name, "_hi"}, hi, e.hi);
          checkOutput({e.name, "_lo"}, lo, e.lo);
        end
        run = 0;
      end
    end
  end

  initial begin
    reset = 1'b1;
    op    = MD_OP_NONE;
    a     = 32'd0;
    b     = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_hi", hi, 32'd0);
    checkOutput("reset_lo", lo, 32'd0);
    mon_en = 1'b1;

    // Signed multiply: -3 * 5 = -15.
    expect_result("mult_neg", 32'hFFFF_FFFF, 32'hFFFF_FFF1, 6);
    applyStimulus(MD_OP_MULT, 32'hFFFF_FFFD, 32'd5);
    waitDone("mult_neg");

    // Unsigned multiply: 0xFFFFFFFF * 2.
    expect_result("multu", 32'h0000_0001, 32'hFFFF_FFFE, 6);
    applyStimulus(MD_OP_MULTU, 32'hFFFF_FFFF, 32'd2);
    waitDone("multu");

    // Signed divide: -7 / 2 = -3 rem -1.
    expect_result("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 11);
    applyStimulus(MD_OP_DIV, 32'hFFFF_FFF9, 32'd2);
    waitDone("div_neg");

    // Signed divide: 7 / -2 = -3 rem 1.
    expect_result("div_negdivisor", 32'h0000_0001, 32'hFFFF_FFFD, 11);
    applyStimulus(MD_OP_DIV, 32'd7, 32'hFFFF_FFFE);
    waitDone("div_negdivisor");

    // Overflow case of signed divide.
    expect_result("div_ovf", 32'h0000_0000, 32'h8000_0000, 11);
    applyStimulus(MD_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    waitDone("div_ovf");

    // Moves take effect the next cycle with no busy.
    applyStimulus(MD_OP_MTHI, 32'h1234_5678, 32'd0);
    checkOutput("mthi_hi", hi, 32'h1234_5678);
    applyStimulus(MD_OP_MTLO, 32'h9ABC_DEF0, 32'd0);
    checkOutput("mtlo_lo", lo, 32'h9ABC_DEF0);
    checkOutput("mtlo_hi_kept", hi, 32'h1234_5678);

    // Divide by zero keeps HI/LO after the full latency.
    expect_result("divu_zero", 32'h1234_5678, 32'h9ABC_DEF0, 11);
    applyStimulus(MD_OP_DIVU, 32'd7, 32'd0);
    waitDone("divu_zero");

    // MTLO issued while busy is ignored; LO holds the product.
    expect_result("mult_mtlo", 32'h0000_0001, 32'h2345_0000, 6);
    applyStimulus(MD_OP_MULT, 32'h0001_2345, 32'h0001_0000);
    @(posedge clk);
    #1;
    applyStimulus(MD_OP_MTLO, 32'h0000_AAAA, 32'd0);
    waitDone("mult_mtlo");

    // Back-to-back: DIVU issued in the first idle cycle after a MULTU.
    // The DIVU is driven after that cycle's monitor sample, so its busy run
    // is seen as DIV_CYCLES samples.
    expect_result("b2b_multu", 32'h0000_0000, 32'h0000_0015, 6);
    expect_result("b2b_divu", 32'h0000_0002, 32'h0000_000E, 10);
    applyStimulus(MD_OP_MULTU, 32'd3, 32'd7);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      if (!busy) break;
    end
    applyStimulus(MD_OP_DIVU, 32'd100, 32'd7);
    waitDone("b2b");

    // Reset during a divide discards it and clears HI/LO.
    expect_result("div_reset", 32'd0, 32'd0, 5);
    applyStimulus(MD_OP_DIV, 32'd1000, 32'd3);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    waitDone("div_reset");
    repeat (12) @(posedge clk);
    #1;
    checkOutput("post_reset_hi", hi, 32'd0);
    checkOutput("post_reset_lo", lo, 32'd0);
    checkOutput("post_reset_busy", {31'd0, busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
